// File: rtl/sdsp_update_engine.sv
// SDSP synaptic update engine: read-modify-write of one packed synapse word
// per request, applying UP/DOWN weight steps to eligible plastic synapses.
module sdsp_update_engine #(
   parameter int N_SYN = 8,
   parameter int AW    = 13
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               upd_req,
   input  logic [AW-1:0]      upd_addr,
   input  logic               upd_vup,
   input  logic               upd_vdown,
   input  logic [N_SYN-1:0]   upd_mask,
   input  logic               param_learn,
   output logic               upd_ack,
   output logic [3:0]         upd_nchg,
   output logic               busy,
   output logic               sram_cs,
   output logic               sram_we,
   output logic [AW-1:0]      sram_addr,
   output logic [4*N_SYN-1:0] sram_wdata,
   input  logic [4*N_SYN-1:0] sram_rdata
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_RDW,
      S_WR,
      S_ACK
   } state_t;

   state_t state_q, state_d;

   logic             vup_q, vdown_q, learn_q;
   logic [N_SYN-1:0] mask_q;

   logic [4*N_SYN-1:0] new_word;
   logic [3:0]         chg_cnt;

   logic               accept;
   logic               cs_d, we_d, ack_d, busy_d;
   logic [3:0]         nchg_d;
   logic [4*N_SYN-1:0] wdata_d;

   // Per-lane SDSP rule; the plastic bit is carried through untouched.
   always_comb begin
      new_word = sram_rdata;
      chg_cnt  = '0;
      for (int i = 0; i < N_SYN; i++) begin
         if (sram_rdata[4*i+3] && mask_q[i] && learn_q) begin
            if (vup_q && !vdown_q && sram_rdata[4*i +: 3] != 3'd7) begin
               new_word[4*i +: 3] = sram_rdata[4*i +: 3] + 3'd1;
               chg_cnt            = chg_cnt + 4'd1;
            end else if (vdown_q && !vup_q &&
                         sram_rdata[4*i +: 3] != 3'd0) begin
               new_word[4*i +: 3] = sram_rdata[4*i +: 3] - 3'd1;
               chg_cnt            = chg_cnt + 4'd1;
            end
         end
      end
   end

   // Next state and next values of the registered outputs.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      cs_d    = 1'b0;
      we_d    = 1'b0;
      ack_d   = 1'b0;
      busy_d  = busy;
      nchg_d  = upd_nchg;
      wdata_d = sram_wdata;
      unique case (state_q)
         S_IDLE: begin
            if (upd_req) begin
               accept  = 1'b1;
               cs_d    = 1'b1;
               busy_d  = 1'b1;
               state_d = S_RD;
            end
         end
         S_RD: begin
            state_d = S_RDW;
         end
         S_RDW: begin
            nchg_d = chg_cnt;
            if (chg_cnt != 4'd0) begin
               cs_d    = 1'b1;
               we_d    = 1'b1;
               wdata_d = new_word;
               state_d = S_WR;
            end else begin
               ack_d   = 1'b1;
               state_d = S_ACK;
            end
         end
         S_WR: begin
            ack_d   = 1'b1;
            state_d = S_ACK;
         end
         S_ACK: begin
            busy_d  = 1'b0;
            nchg_d  = '0;
            state_d = S_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge CLK) begin
      if (RST) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Output registers and request latches.
   always_ff @(posedge CLK) begin
      if (RST) begin
         upd_ack    <= 1'b0;
         upd_nchg   <= '0;
         busy       <= 1'b0;
         sram_cs    <= 1'b0;
         sram_we    <= 1'b0;
         sram_addr  <= '0;
         sram_wdata <= '0;
         vup_q      <= 1'b0;
         vdown_q    <= 1'b0;
         learn_q    <= 1'b0;
         mask_q     <= '0;
      end else begin
         upd_ack    <= ack_d;
         upd_nchg   <= nchg_d;
         busy       <= busy_d;
         sram_cs    <= cs_d;
         sram_we    <= we_d;
         sram_wdata <= wdata_d;
         if (accept) begin
            sram_addr <= upd_addr;
            vup_q     <= upd_vup;
            vdown_q   <= upd_vdown;
            learn_q   <= param_learn;
            mask_q    <= upd_mask;
         end
      end
   end

endmodule

// File: tb/tb_sdsp_update_engine.sv
// Directed bench for sdsp_update_engine with a behavioural single-port
// synapse SRAM (one-cycle read latency) and a preload port.
module tb_sdsp_update_engine;

   localparam int N_SYN = 8;
   localparam int AW    = 13;
   localparam int DW    = 4*N_SYN;

   logic          clk = 1'b0;
   logic          rst;
   logic          upd_req;
   logic [AW-1:0] upd_addr;
   logic          upd_vup, upd_vdown;
   logic [N_SYN-1:0] upd_mask;
   logic          param_learn;
   logic          upd_ack;
   logic [3:0]    upd_nchg;
   logic          busy;
   logic          sram_cs, sram_we;
   logic [AW-1:0] sram_addr;
   logic [DW-1:0] sram_wdata;
   logic [DW-1:0] sram_rdata;

   logic          pl_en;
   logic [3:0]    pl_addr;
   logic [DW-1:0] pl_data;
   logic [DW-1:0] mem [0:15];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   sdsp_update_engine #(.N_SYN(N_SYN), .AW(AW)) dut (
      .CLK         (clk),
      .RST         (rst),
      .upd_req     (upd_req),
      .upd_addr    (upd_addr),
      .upd_vup     (upd_vup),
      .upd_vdown   (upd_vdown),
      .upd_mask    (upd_mask),
      .param_learn (param_learn),
      .upd_ack     (upd_ack),
      .upd_nchg    (upd_nchg),
      .busy        (busy),
      .sram_cs     (sram_cs),
      .sram_we     (sram_we),
      .sram_addr   (sram_addr),
      .sram_wdata  (sram_wdata),
      .sram_rdata  (sram_rdata)
   );

   // Synapse SRAM model with a bench-side preload port.
   always @(posedge clk) begin
      if (pl_en) mem[pl_addr] <= pl_data;
      else if (sram_cs) begin
         if (sram_we) mem[sram_addr[3:0]] <= sram_wdata;
         else         sram_rdata <= mem[sram_addr[3:0]];
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [3:0] a, input logic [DW-1:0] d);
      pl_en   = 1'b1;
      pl_addr = a;
      pl_data = d;
      tick();
      pl_en   = 1'b0;
   endtask

   // One request from IDLE; checks every cycle up to the return to IDLE.
   task automatic run(input string tag, input logic [3:0] a,
                      input logic vu, input logic vd,
                      input logic [7:0] m, input logic lrn,
                      input logic wr, input logic [DW-1:0] exp_word,
                      input logic [3:0] exp_nchg);
      upd_req     = 1'b1;
      upd_addr    = {9'd0, a};
      upd_vup     = vu;
      upd_vdown   = vd;
      upd_mask    = m;
      param_learn = lrn;
      tick();
      upd_req = 1'b0;
      chk({tag, " rd cs/we/busy"}, {29'd0, sram_cs, sram_we, busy}, 32'b101);
      chk({tag, " rd addr"}, {19'd0, sram_addr}, {28'd0, a});
      tick();
      chk({tag, " rdw cs/ack"}, {30'd0, sram_cs, upd_ack}, 32'd0);
      tick();
      if (wr) begin
         chk({tag, " wr cs/we"}, {30'd0, sram_cs, sram_we}, 32'b11);
         chk({tag, " wr data"}, sram_wdata, exp_word);
         tick();
      end else begin
         chk({tag, " no-wr we"}, {31'd0, sram_we}, 32'd0);
      end
      chk({tag, " ack/busy"}, {30'd0, upd_ack, busy}, 32'b11);
      chk({tag, " nchg"}, {28'd0, upd_nchg}, {28'd0, exp_nchg});
      tick();
      chk({tag, " idle ack/busy/cs"}, {29'd0, upd_ack, busy, sram_cs}, 32'd0);
      chk({tag, " mem"}, mem[a], exp_word);
   endtask

   int acks[$];
   logic we_seen;

   initial begin
      rst         = 1'b1;
      upd_req     = 1'b0;
      upd_addr    = '0;
      upd_vup     = 1'b0;
      upd_vdown   = 1'b0;
      upd_mask    = '0;
      param_learn = 1'b1;
      pl_en       = 1'b0;
      pl_addr     = '0;
      pl_data     = '0;
      tick();
      tick();
      chk("reset ctrl", {27'd0, upd_ack, busy, sram_cs, sram_we, 1'b0}, 32'd0);
      chk("reset nchg", {28'd0, upd_nchg}, 32'd0);
      chk("reset addr", {19'd0, sram_addr}, 32'd0);
      chk("reset wdata", sram_wdata, 32'd0);
      rst = 1'b0;
      tick();

      preload(4'd1, 32'hFFFF_FFFF);
      run("sat up", 4'd1, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 4'd0);

      preload(4'd2, 32'h8888_8888);
      run("up mask0f", 4'd2, 1'b1, 1'b0, 8'h0F, 1'b1, 1'b1,
          32'h8888_9999, 4'd4);
      chk("wdata hold", sram_wdata, 32'h8888_9999);

      preload(4'd3, 32'hFB3A_C5D1);
      run("down mix", 4'd3, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1,
          32'hEA39_B5C1, 4'd5);

      preload(4'd4, 32'h8888_8888);
      run("up+down", 4'd4, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0,
          32'h8888_8888, 4'd0);
      run("sat down", 4'd4, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0,
          32'h8888_8888, 4'd0);
      run("learn off", 4'd4, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0,
          32'h8888_8888, 4'd0);

      preload(4'd7, 32'h1234_5678);
      run("mask a5", 4'd7, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1,
          32'h1234_5679, 4'd1);

      // Request held high with learning off: back-to-back, no writes.
      preload(4'd6, 32'h8888_8888);
      we_seen     = 1'b0;
      upd_req     = 1'b1;
      upd_addr    = 13'd6;
      upd_vup     = 1'b1;
      upd_vdown   = 1'b0;
      upd_mask    = 8'hFF;
      param_learn = 1'b0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (upd_ack) begin
            acks.push_back(c);
            chk("b2b nchg", {28'd0, upd_nchg}, 32'd0);
         end
         if (sram_we) we_seen = 1'b1;
      end
      upd_req = 1'b0;
      chk("b2b ack count", acks.size(), 32'd3);
      if (acks.size() >= 3) begin
         chk("b2b spacing 1", acks[1] - acks[0], 32'd4);
         chk("b2b spacing 2", acks[2] - acks[1], 32'd4);
      end
      chk("b2b no write", {31'd0, we_seen}, 32'd0);
      tick();
      tick();
      chk("b2b idle busy", {31'd0, busy}, 32'd0);
      param_learn = 1'b1;

      // Reset at the RDW->WR transition of a writing transaction.
      preload(4'd5, 32'h8888_8888);
      upd_req  = 1'b1;
      upd_addr = 13'd5;
      upd_mask = 8'hFF;
      upd_vup  = 1'b1;
      tick();
      upd_req = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst cs/we/busy/ack", {28'd0, sram_cs, sram_we, busy, upd_ack},
          32'd0);
      we_seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (upd_ack || sram_we || busy) we_seen = 1'b1;
      end
      chk("rst no ack/write", {31'd0, we_seen}, 32'd0);
      chk("rst mem kept", mem[5], 32'h8888_8888);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
